tick_time_counter: RTL and testbench

- Consumer end of the 1 Hz tick interface: takes the single-cycle tick pulse produced by the clock divider and advances a BCD MM:SS timekeeper.
- Provides run/pause control and a manual adjust mode, and emits a rollover pulse.
- BCD digit outputs feed the seven-segment display driver directly.

---
 rtl/tick_time_counter.sv | 117 +++++++++++
 tb/tb_tick_time_counter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_time_counter.sv
// BCD MM:SS timekeeper driven by the divider's 1 Hz tick pulse.
// Provides run/pause toggle, manual field adjust and a 59:59 -> 00:00 rollover pulse.
module tick_time_counter #(
  parameter int unsigned TICKS_PER_STEP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       rollover
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam logic [7:0] STEP_LAST = 8'(TICKS_PER_STEP - 1);

  state_t     state, state_nx;
  logic       pb_q;
  logic       rise;
  logic [7:0] prescale, prescale_nx;
  logic [7:0] secs, secs_nx;
  logic [7:0] mins, mins_nx;
  logic       roll_nx;

  // Advance a two-digit BCD field 00..59, wrapping to 00.
  function automatic logic [7:0] inc59(input logic [7:0] v);
    logic [3:0] t;
    logic [3:0] o;
    t = v[7:4];
    o = v[3:0];
    if (o >= 4'd9) begin
      o = '0;
      t = (t >= 4'd5) ? 4'd0 : t + 4'd1;
    end else begin
      o = o + 4'd1;
    end
    return {t, o};
  endfunction

  assign rise = pause_btn & ~pb_q;

  always_comb begin
    state_nx = state;
    case (state)
      ST_PAUSED: if (adj) state_nx = ST_ADJUST; else if (rise) state_nx = ST_RUN;
      ST_RUN:    if (adj) state_nx = ST_ADJUST; else if (rise) state_nx = ST_PAUSED;
      ST_ADJUST: if (!adj) state_nx = ST_PAUSED;
      default:   state_nx = ST_PAUSED;
    endcase
  end

  // Ticks are interpreted by the current state; a same-cycle state change only affects later ticks.
  always_comb begin
    prescale_nx = prescale;
    secs_nx     = secs;
    mins_nx     = mins;
    roll_nx     = 1'b0;
    if (tick) begin
      case (state)
        ST_RUN: begin
          if (prescale >= STEP_LAST) begin
            prescale_nx = '0;
            secs_nx     = inc59(secs);
            if (secs == 8'h59) begin
              mins_nx = inc59(mins);
              roll_nx = (mins == 8'h59);
            end
          end else begin
            prescale_nx = prescale + 8'd1;
          end
        end
        ST_ADJUST: begin
          if (sel) mins_nx = inc59(mins);
          else     secs_nx = inc59(secs);
        end
        default: ;
      endcase
    end
    if (state != ST_ADJUST && state_nx == ST_ADJUST) prescale_nx = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_PAUSED;
      pb_q     <= 1'b0;
      prescale <= '0;
      secs     <= '0;
      mins     <= '0;
      rollover <= 1'b0;
    end else begin
      state    <= state_nx;
      pb_q     <= pause_btn;
      prescale <= prescale_nx;
      secs     <= secs_nx;
      mins     <= mins_nx;
      rollover <= roll_nx;
    end
  end

  assign min_tens = mins[7:4];
  assign min_ones = mins[3:0];
  assign sec_tens = secs[7:4];
  assign sec_ones = secs[3:0];
  assign running  = (state == ST_RUN);

endmodule

// File: tb/tb_tick_time_counter.sv
// Directed self-checking bench for tick_time_counter: one instance with
// TICKS_PER_STEP=1 and one with TICKS_PER_STEP=4.
module tb_tick_time_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A (TICKS_PER_STEP = 1)
  logic rst, tick, pb, adj, sel;
  logic [3:0] mt, mo, st, so;
  logic running, rollover;
  logic [15:0] t1;
  assign t1 = {mt, mo, st, so};

  // Instance B (TICKS_PER_STEP = 4)
  logic rst4, tick4, pb4, adj4, sel4;
  logic [3:0] mt4, mo4, st4, so4;
  logic running4, rollover4;
  logic [15:0] t4;
  assign t4 = {mt4, mo4, st4, so4};

  int n_cmp = 0;
  int n_bad = 0;

  tick_time_counter #(.TICKS_PER_STEP(1)) dut (
    .clk(clk), .rst(rst), .tick(tick), .pause_btn(pb), .adj(adj), .sel(sel),
    .min_tens(mt), .min_ones(mo), .sec_tens(st), .sec_ones(so),
    .running(running), .rollover(rollover)
  );

  tick_time_counter #(.TICKS_PER_STEP(4)) dut4 (
    .clk(clk), .rst(rst4), .tick(tick4), .pause_btn(pb4), .adj(adj4), .sel(sel4),
    .min_tens(mt4), .min_ones(mo4), .sec_tens(st4), .sec_ones(so4),
    .running(running4), .rollover(rollover4)
  );

  // Advance one clock; inputs set afterwards are sampled on the next edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Single-cycle tick on instance A followed by idle cycles.
  task automatic pulse_tick(input int gap);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(gap);
  endtask

  task automatic pulse_tick4(input int gap);
    tick4 = 1'b1;
    step(1);
    tick4 = 1'b0;
    step(gap);
  endtask

  task automatic press_pb4;
    pb4 = 1'b1;
    step(1);
    pb4 = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    rst = 1'b1; rst4 = 1'b1;
    step(2);
    rst = 1'b0; rst4 = 1'b0;
    n_cmp++;
    if (t1 !== 16'h0000) begin n_bad++; $display("FAIL reset_digits: got %h expected 0000", t1); end
    n_cmp++;
    if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b expected 0", running); end
    n_cmp++;
    if (rollover !== 1'b0) begin n_bad++; $display("FAIL reset_rollover: got %b expected 0", rollover); end
    pb = 1'b1;
    step(2);
    pb = 1'b0;
    n_cmp++;
    if (running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %b expected 1", running); end
    step(1);
  endtask

  task automatic test_run_count;
    for (int k = 1; k <= 75; k++) begin
      pulse_tick(9);
      if (k == 59) begin
        n_cmp++;
        if (t1 !== 16'h0059) begin n_bad++; $display("FAIL run_at_59: got %h expected 0059", t1); end
      end
      if (k == 60) begin
        n_cmp++;
        if (t1 !== 16'h0100) begin n_bad++; $display("FAIL run_carry_min: got %h expected 0100", t1); end
      end
    end
    n_cmp++;
    if (t1 !== 16'h0115) begin n_bad++; $display("FAIL run_75: got %h expected 0115", t1); end
  endtask

  task automatic test_rollover;
    int roll_seen;
    adj = 1'b1; sel = 1'b1;
    step(1);
    tick = 1'b1;
    step(58);            // minutes 01 -> 59
    sel = 1'b0;
    step(43);            // seconds 15 -> 58
    tick = 1'b0; adj = 1'b0;
    step(1);
    n_cmp++;
    if (t1 !== 16'h5958) begin n_bad++; $display("FAIL preload: got %h expected 5958", t1); end
    n_cmp++;
    if (running !== 1'b0) begin n_bad++; $display("FAIL adj_exit_paused: got %b expected 0", running); end
    pb = 1'b1; step(1); pb = 1'b0; step(1);
    pulse_tick(0);
    n_cmp++;
    if (t1 !== 16'h5959 || rollover !== 1'b0) begin
      n_bad++; $display("FAIL tick_5959: got %h roll %b expected 5959 roll 0", t1, rollover);
    end
    pulse_tick(0);
    n_cmp++;
    if (t1 !== 16'h0000 || rollover !== 1'b1) begin
      n_bad++; $display("FAIL wrap_0000: got %h roll %b expected 0000 roll 1", t1, rollover);
    end
    roll_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (rollover) roll_seen++;
    end
    n_cmp++;
    if (roll_seen !== 0) begin n_bad++; $display("FAIL roll_one_cycle: got %0d extra high cycles expected 0", roll_seen); end
  endtask

  task automatic test_pause_with_tick;
    pb = 1'b1; tick = 1'b1;
    step(1);
    pb = 1'b0; tick = 1'b0;
    n_cmp++;
    if (t1 !== 16'h0001 || running !== 1'b0) begin
      n_bad++; $display("FAIL pause_same_tick: got %h run %b expected 0001 run 0", t1, running);
    end
    for (int i = 0; i < 5; i++) pulse_tick(2);
    n_cmp++;
    if (t1 !== 16'h0001) begin n_bad++; $display("FAIL paused_hold: got %h expected 0001", t1); end
  endtask

  task automatic test_adjust_minutes;
    int roll_seen;
    rst = 1'b1; step(1); rst = 1'b0;
    adj = 1'b1; sel = 1'b1;
    step(1);
    roll_seen = 0;
    tick = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      step(1);
      if (rollover) roll_seen++;
      if (k == 59) begin
        n_cmp++;
        if (t1 !== 16'h5900) begin n_bad++; $display("FAIL adj_min_59: got %h expected 5900", t1); end
      end
      if (k == 60) begin
        n_cmp++;
        if (t1 !== 16'h0000) begin n_bad++; $display("FAIL adj_min_wrap: got %h expected 0000", t1); end
      end
    end
    tick = 1'b0;
    n_cmp++;
    if (t1 !== 16'h0100) begin n_bad++; $display("FAIL adj_min_61: got %h expected 0100", t1); end
    n_cmp++;
    if (roll_seen !== 0) begin n_bad++; $display("FAIL adj_no_roll: got %0d expected 0", roll_seen); end
    // Seconds field wraps without carrying into minutes.
    sel = 1'b0; tick = 1'b1;
    step(60);
    tick = 1'b0;
    n_cmp++;
    if (t1 !== 16'h0100) begin n_bad++; $display("FAIL adj_sec_nocarry: got %h expected 0100", t1); end
    adj = 1'b0;
    step(1);
    n_cmp++;
    if (running !== 1'b0) begin n_bad++; $display("FAIL adj_to_paused: got %b expected 0", running); end
    pb = 1'b1; step(1); pb = 1'b0; step(1);
    n_cmp++;
    if (running !== 1'b1) begin n_bad++; $display("FAIL resume_after_adj: got %b expected 1", running); end
  endtask

  task automatic test_prescale;
    press_pb4();
    n_cmp++;
    if (running4 !== 1'b1) begin n_bad++; $display("FAIL p4_run: got %b expected 1", running4); end
    for (int k = 1; k <= 10; k++) begin
      pulse_tick4(1);
      if (k == 3) begin
        n_cmp++;
        if (t4 !== 16'h0000) begin n_bad++; $display("FAIL p4_3ticks: got %h expected 0000", t4); end
      end
      if (k == 4) begin
        n_cmp++;
        if (t4 !== 16'h0001) begin n_bad++; $display("FAIL p4_4ticks: got %h expected 0001", t4); end
      end
    end
    n_cmp++;
    if (t4 !== 16'h0002) begin n_bad++; $display("FAIL p4_10ticks: got %h expected 0002", t4); end
    press_pb4();
    for (int i = 0; i < 3; i++) pulse_tick4(1);
    n_cmp++;
    if (t4 !== 16'h0002 || running4 !== 1'b0) begin
      n_bad++; $display("FAIL p4_paused: got %h run %b expected 0002 run 0", t4, running4);
    end
    press_pb4();
    pulse_tick4(1);
    n_cmp++;
    if (t4 !== 16'h0002) begin n_bad++; $display("FAIL p4_resume1: got %h expected 0002", t4); end
    pulse_tick4(1);
    n_cmp++;
    if (t4 !== 16'h0003) begin n_bad++; $display("FAIL p4_resume2: got %h expected 0003", t4); end
    pulse_tick4(1);
    rst4 = 1'b1; tick4 = 1'b1; pb4 = 1'b1;
    step(1);
    rst4 = 1'b0; tick4 = 1'b0; pb4 = 1'b0;
    n_cmp++;
    if (t4 !== 16'h0000 || running4 !== 1'b0 || rollover4 !== 1'b0) begin
      n_bad++; $display("FAIL p4_midreset: got %h run %b roll %b expected 0000 run 0 roll 0", t4, running4, rollover4);
    end
    // Prescale was cleared by reset: a full four ticks are needed again.
    press_pb4();
    for (int i = 0; i < 3; i++) pulse_tick4(1);
    n_cmp++;
    if (t4 !== 16'h0000) begin n_bad++; $display("FAIL p4_post_reset3: got %h expected 0000", t4); end
    pulse_tick4(1);
    n_cmp++;
    if (t4 !== 16'h0001) begin n_bad++; $display("FAIL p4_post_reset4: got %h expected 0001", t4); end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; pb = 1'b0; adj = 1'b0; sel = 1'b0;
    rst4 = 1'b1; tick4 = 1'b0; pb4 = 1'b0; adj4 = 1'b0; sel4 = 1'b0;
    test_reset();
    test_run_count();
    test_rollover();
    test_pause_with_tick();
    test_adjust_minutes();
    test_prescale();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
